// File: rtl/cp0_defs.sv
// Shared CP0 constants: register addresses ({rd, sel}), exception codes and
// reset values used by the register file and its timer.
package cp0_defs;

    localparam logic [7:0] CP0_BADVADDR = {5'd8, 3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9, 3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // BEV is hard-wired to 1; every other Status bit resets to 0.
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches a match
// until software rewrites Compare.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti,
    output logic        ti_next
);

    logic tick;

    // A Compare write clears TI even when the match is still true this cycle.
    assign ti_next = compare_we ? 1'b0 : ((count == compare) ? 1'b1 : ti);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick    <= 1'b0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (count_we) begin
                count <= wdata;
            end else if (tick) begin
                count <= count + 32'd1;
            end
            if (compare_we) begin
                compare <= wdata;
            end
            ti <= ti_next;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause and EPC with
// exception/ERET commit, MTC0/MFC0 access and interrupt request generation.
module cp0_regfile
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_we,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        eret,
    input  logic [5:0]  ext_int,
    output logic [31:0] cp0_rdata,
    output logic [31:0] cp0_epc,
    output logic        cp0_status_exl,
    output logic        int_req
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_excode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        ti_next;
    logic        sw_we;
    logic [7:0]  cause_ip;

    // Exceptions and ERET both squash a same-cycle MTC0.
    assign sw_we    = mtc0_we & ~wb_ex & ~eret;
    assign cause_ip = {cause_ip_hw, cause_ip_sw};

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (sw_we && (cp0_addr == CP0_COUNT)),
        .compare_we (sw_we && (cp0_addr == CP0_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti),
        .ti_next    (ti_next)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_im    <= 8'd0;
            status_exl   <= 1'b0;
            status_ie    <= 1'b0;
            cause_bd     <= 1'b0;
            cause_ip_hw  <= 6'd0;
            cause_ip_sw  <= 2'd0;
            cause_excode <= 5'd0;
            epc          <= 32'd0;
            badvaddr     <= 32'd0;
        end else begin
            // IP7 samples TI's next value so it rises and falls with Cause.TI.
            cause_ip_hw <= {ti_next | ext_int[5], ext_int[4:0]};
            if (wb_ex) begin
                if (!status_exl) begin
                    epc      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                    cause_bd <= wb_bd;
                end
                cause_excode <= wb_excode;
                status_exl   <= 1'b1;
                if ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES)) begin
                    badvaddr <= wb_badvaddr;
                end
            end else if (eret) begin
                status_exl <= 1'b0;
            end else if (mtc0_we) begin
                case (cp0_addr)
                    CP0_STATUS: begin
                        status_im  <= cp0_wdata[15:8];
                        status_exl <= cp0_wdata[1];
                        status_ie  <= cp0_wdata[0];
                    end
                    CP0_CAUSE: cause_ip_sw <= cp0_wdata[9:8];
                    CP0_EPC:   epc         <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = badvaddr;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = STATUS_RESET | {16'd0, status_im, 6'd0, status_exl, status_ie};
            CP0_CAUSE:    cp0_rdata = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'b00};
            CP0_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign cp0_epc        = epc;
    assign cp0_status_exl = status_exl;
    assign int_req        = status_ie & ~status_exl & (|(cause_ip & status_im));

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL: clk  in  1  sole clock, rising edge.
REQ-002 SHALL: resetn  in  1  reset, synchronous and active-low.
REQ-003 SHALL: mtc0_we  in  1  MTC0 write strobe from WB stage.
REQ-004 SHALL: cp0_addr  in  8  {rd[4:0], sel[2:0]} selecting the register for MTC0/MFC0.
REQ-005 SHALL: cp0_wdata  in  32  MTC0 write data.
REQ-006 SHALL: wb_ex  in  1  exception commit from WB; same signal as the exception-address unit's is_exl input.
REQ-007 SHALL: wb_excode  in  5  ExcCode of the committing exception.
REQ-008 SHALL: wb_bd  in  1  faulting instruction sits in a branch delay slot.
REQ-009 SHALL: wb_pc  in  32  PC of the faulting instruction.
REQ-010 SHALL: wb_badvaddr  in  32  faulting address for AdEL/AdES.
REQ-011 SHALL: eret  in  1  ERET commit from WB.
REQ-012 SHALL: ext_int  in  6  hardware interrupt lines, level-sensitive.
REQ-013 SHALL: cp0_rdata  out  32  MFC0 read data, combinational on cp0_addr.
REQ-014 SHALL: cp0_epc  out  32  current EPC, feeds the exception-address unit.
REQ-015 SHALL: cp0_status_exl  out  1  Status.EXL.
REQ-016 SHALL: int_req  out  1  interrupt request to the pipeline.

Function
REQ-017 SHALL implement BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0) and EPC (14,0); unmapped addresses read 0.
REQ-018 SHALL allow only these bits to be written/read: Status = BEV[22] (read-only 1), IM[15:8], EXL[1], IE[0]. Cause = BD[31], TI[30], IP[15:8], ExcCode[6:2]. Cause is software-writable only at IP[9:8]. Every other bit SHALL read 0.
REQ-019 SHALL increment Count by 1 every second cycle via an internal tick flop that toggles each cycle; Count increments when tick=1 and wraps from 0xFFFF_FFFF to 0.
REQ-020 SHALL set Cause.TI one cycle after Count==Compare is observed, and hold it until Compare is written.
REQ-021 SHALL, on a Compare write, clear TI in the same edge; the clear wins over a simultaneous match.
REQ-022 SHALL register Cause.IP[15:10] each cycle as {TI|ext_int[5], ext_int[4:0]}.
REQ-023 SHALL drive int_req = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinationally.
REQ-024 SHALL, on wb_ex with EXL=0: set EPC = wb_bd ? wb_pc-4 : wb_pc; set Cause.BD = wb_bd.
REQ-025 SHALL, on wb_ex regardless of EXL: set ExcCode = wb_excode and EXL = 1; EPC and BD SHALL stay unchanged if EXL was already 1.
REQ-026 SHALL, on wb_ex with ExcCode 0x04 (AdEL) or 0x05 (AdES): load BadVAddr = wb_badvaddr.
REQ-027 SHALL clear EXL on eret.
REQ-028 SHALL apply this priority within one cycle: wb_ex > eret > mtc0_we; lower-priority writes are dropped.
REQ-029 SHALL let an MTC0 write to Count take precedence over that cycle's increment.
REQ-030 SHALL make all register updates visible on cp0_rdata/cp0_epc the cycle after the edge; no write-through bypass.

Reset
REQ-031 SHALL, while resetn=0 at a clock edge, load: Status=0x0040_0000, Cause=0, EPC=0, Count=0, Compare=0, BadVAddr=0, tick=0.
REQ-032 SHALL therefore output int_req=0, cp0_status_exl=0 and cp0_epc=0 in the cycle after reset.
REQ-033 SHALL let reset asserted mid-exception override every simultaneous wb_ex/eret/mtc0.

Structure
REQ-034 SHALL place the register-number constants (addr encodings), ExcCode values (Int=0x00, AdEL=0x04, AdES=0x05, Sys=0x08, Bp=0x09, RI=0x0A, Ov=0x0C) and the Status reset value in the shared package cp0_defs.
REQ-035 SHALL implement Count/Compare/TI and the tick in one sub-module, cp0_timer.

Verification
REQ-036 Reset, then 10 idle cycles -> Count=5, Status reads 0x0040_0000, int_req=0.
REQ-037 wb_ex, excode=0x0C, wb_bd=1, wb_pc=0xBFC0_1004 -> EPC=0xBFC0_1000, Cause=0x8000_0030, EXL=1; eret next cycle -> EXL=0.
REQ-038 Second wb_ex (pc=0x100) while EXL=1 -> EPC unchanged, ExcCode updated.
REQ-039 MTC0 Compare=0x10, Status=0x0000_8001 -> TI set after Count reaches 0x10, int_req=1; MTC0 Compare -> TI=0 and int_req=0 next cycle.
REQ-040 Same-cycle wb_ex(AdEL, badvaddr=0x1235) + mtc0 Status + eret -> BadVAddr=0x1235, EXL=1, Status write dropped.
REQ-041 MTC0 Count=0xFFFF_FFFF, then 4 cycles -> Count=0x0000_0001 (wrap).
